// File: rtl/hazard_sched_ctrl.sv
// Hazard and stall scheduler for the 5-stage core: forwarding selects, load-use
// and branch-compare interlocks, MDU occupancy sequencing and data-memory freeze.
module hazard_sched_ctrl #(
  parameter int MDU_LAT = 4
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       MemtoRegM,
  input  logic       BranchD,
  input  logic       PCSrcD,
  input  logic       JumpD,
  input  logic       MduOpE,
  input  logic       MemAccessM,
  input  logic       dmem_ready,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       FlushW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic       MduStart,
  output logic       MduBusy
);

  typedef enum logic {
    RUN = 1'b0,
    MDU = 1'b1
  } state_t;

  // The counter is loaded so that it reaches zero in the last MDU cycle.
  localparam logic [3:0] CNT_LOAD = 4'(MDU_LAT - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       lwstall, brstall, memwait, mdustall;

  // Execute-stage operand select: M result has priority over W result.
  function automatic logic [1:0] fwd_exec(input logic [4:0] src,
                                          input logic       wr_m,
                                          input logic [4:0] dst_m,
                                          input logic       wr_w,
                                          input logic [4:0] dst_w);
    if (src != 5'd0 && wr_m && dst_m == src)      return 2'b10;
    else if (src != 5'd0 && wr_w && dst_w == src) return 2'b01;
    else                                          return 2'b00;
  endfunction

  function automatic logic hits_decode(input logic [4:0] dst,
                                       input logic [4:0] rs,
                                       input logic [4:0] rt);
    return (dst == rs) || (dst == rt);
  endfunction

  assign ForwardAE = fwd_exec(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
  assign ForwardBE = fwd_exec(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
  assign ForwardAD = (RsD != 5'd0) && RegWriteM && (WriteRegM == RsD);
  assign ForwardBD = (RtD != 5'd0) && RegWriteM && (WriteRegM == RtD);

  assign lwstall = MemtoRegE && hits_decode(RtE, RsD, RtD);
  assign brstall = BranchD &&
                   ((RegWriteE && hits_decode(WriteRegE, RsD, RtD)) ||
                    (MemtoRegM && hits_decode(WriteRegM, RsD, RtD)));
  assign memwait = MemAccessM && !dmem_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every combinational output is given a default before the case so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    MduStart = 1'b0;
    mdustall = 1'b0;
    unique case (state_q)
      RUN: begin
        // A launch blocked by a memory wait is simply retried next cycle.
        if (MduOpE && !memwait) begin
          MduStart = 1'b1;
          mdustall = 1'b1;
          cnt_d    = CNT_LOAD;
          state_d  = MDU;
        end
      end
      MDU: begin
        mdustall = (cnt_q != 4'd0);
        if (memwait) begin
          cnt_d = cnt_q;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    endcase
  end

  assign MduBusy = (state_q == MDU);

  // Memory wait freezes M and everything behind it; nothing is flushed.
  assign StallM = memwait;
  assign FlushW = memwait;
  assign StallE = memwait || mdustall;
  assign FlushM = mdustall && !memwait;
  assign StallD = StallE || lwstall || brstall;
  assign StallF = StallD;
  assign FlushE = (lwstall || brstall) && !StallE;
  assign FlushD = (PCSrcD || JumpD) && !StallD;

endmodule

// File: tb/tb_hazard_sched_ctrl.sv
// Self-checking bench for hazard_sched_ctrl: directed scenarios followed by
// random traffic compared against an occupancy-count model of the scheduler.
module tb_hazard_sched_ctrl;

  localparam int LAT = 4;

  logic       CLK = 1'b0;
  logic       rst;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic       BranchD, PCSrcD, JumpD, MduOpE, MemAccessM, dmem_ready;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic       ForwardAD, ForwardBD, MduStart, MduBusy;

  int n_checks = 0;
  int n_fail   = 0;
  // Model: number of advancing E-cycles the current MDU op has completed (0 = idle).
  int done     = 0;

  hazard_sched_ctrl #(.MDU_LAT(LAT)) dut (
    .CLK(CLK), .rst(rst),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .PCSrcD(PCSrcD), .JumpD(JumpD),
    .MduOpE(MduOpE), .MemAccessM(MemAccessM), .dmem_ready(dmem_ready),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .MduStart(MduStart), .MduBusy(MduBusy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM} = '0;
    {BranchD, PCSrcD, JumpD, MduOpE, MemAccessM, dmem_ready} = '0;
  endtask

  task automatic advance();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [15:0] dut_vec();
    return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
            ForwardAE, ForwardBE, ForwardAD, ForwardBD, MduStart, MduBusy};
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] src);
    if (src != 0 && RegWriteM && WriteRegM == src) return 2'b10;
    if (src != 0 && RegWriteW && WriteRegW == src) return 2'b01;
    return 2'b00;
  endfunction

  // Expected outputs from the scheduling rules and the occupancy count.
  function automatic logic [15:0] model_vec();
    logic mw, busy, launch, mst, lw, br, se, sd;
    mw     = MemAccessM && !dmem_ready;
    busy   = (done != 0);
    launch = !busy && MduOpE && !mw;
    mst    = launch || (busy && done < LAT);
    lw     = MemtoRegE && (RtE == RsD || RtE == RtD);
    br     = BranchD && ((RegWriteE && (WriteRegE == RsD || WriteRegE == RtD)) ||
                         (MemtoRegM && (WriteRegM == RsD || WriteRegM == RtD)));
    se     = mw || mst;
    sd     = se || lw || br;
    return {sd, sd, se, mw, (PCSrcD || JumpD) && !sd, (lw || br) && !se, mst && !mw, mw,
            exp_fwd(RsE), exp_fwd(RtE),
            logic'(RsD != 0 && RegWriteM && WriteRegM == RsD),
            logic'(RtD != 0 && RegWriteM && WriteRegM == RtD),
            launch, busy};
  endfunction

  task automatic model_clock();
    logic mw;
    mw = MemAccessM && !dmem_ready;
    if (done != 0) begin
      if (!mw) done = (done + 1 > LAT) ? 0 : done + 1;
    end else if (MduOpE && !mw) begin
      done = 1;
    end
  endtask

  initial begin
    int se_cnt, fm_cnt, busy_cnt, st_cnt;
    clear_inputs();
    rst = 1'b0;
    #3;
    check("reset_outputs", dut_vec(), 16'h0);
    #9 rst = 1'b1;
    @(negedge CLK);
    check("idle_outputs", dut_vec(), 16'h0);
    advance();

    // Forwarding, all combinational.
    RsE = 5'd3; RtE = 5'd3;
    WriteRegM = 5'd3; RegWriteM = 1'b1; WriteRegW = 5'd3; RegWriteW = 1'b1;
    #1;
    check("fwd_ae_m", 16'(ForwardAE), 16'd2);
    check("fwd_be_m", 16'(ForwardBE), 16'd2);
    RsE = 5'd0;
    #1;
    check("fwd_ae_r0", 16'(ForwardAE), 16'd0);
    check("fwd_be_keep", 16'(ForwardBE), 16'd2);
    RsE = 5'd3; RegWriteM = 1'b0;
    #1;
    check("fwd_ae_w", 16'(ForwardAE), 16'd1);
    RegWriteM = 1'b1; RsD = 5'd3; RtD = 5'd0;
    #1;
    check("fwd_ad", 16'(ForwardAD), 16'd1);
    check("fwd_bd_r0", 16'(ForwardBD), 16'd0);
    clear_inputs();
    advance();

    // Load-use together with a taken branch in D.
    MemtoRegE = 1'b1; RtE = 5'd5; RsD = 5'd5; PCSrcD = 1'b1;
    @(negedge CLK);
    check("lw_stall_fd", {14'd0, StallF, StallD}, 16'h3);
    check("lw_flush_e", 16'(FlushE), 16'd1);
    check("lw_no_stall_e", 16'(StallE), 16'd0);
    check("br_flushd_held", 16'(FlushD), 16'd0);
    advance();
    MemtoRegE = 1'b0;
    @(negedge CLK);
    check("lw_released", {14'd0, StallD, FlushE}, 16'h0);
    check("br_flushd", 16'(FlushD), 16'd1);
    clear_inputs();
    advance();

    // Branch compare against an ALU producer in E, then a load in M.
    BranchD = 1'b1; RsD = 5'd7; RegWriteE = 1'b1; WriteRegE = 5'd7;
    @(negedge CLK);
    check("brstall_e", {14'd0, StallD, FlushE}, 16'h3);
    advance();
    RegWriteE = 1'b0; MemtoRegM = 1'b1; WriteRegM = 5'd7;
    @(negedge CLK);
    check("brstall_m", {14'd0, StallD, FlushE}, 16'h3);
    clear_inputs();
    advance();

    // MDU occupancy with a load-use overlapping the busy phase.
    se_cnt = 0; fm_cnt = 0; busy_cnt = 0; st_cnt = 0;
    MduOpE = 1'b1;
    for (int i = 0; i <= LAT; i++) begin
      if (i == 1) begin MemtoRegE = 1'b1; RtE = 5'd9; RsD = 5'd9; end
      else begin MemtoRegE = 1'b0; RtE = 5'd0; RsD = 5'd0; end
      @(negedge CLK);
      se_cnt += int'(StallE); fm_cnt += int'(FlushM);
      busy_cnt += int'(MduBusy); st_cnt += int'(MduStart);
      check($sformatf("mdu_stall_e_%0d", i), 16'(StallE), 16'(i < LAT));
      if (i == 1) check("mdu_lw_no_flush_e", {14'd0, StallF, FlushE}, 16'h2);
      advance();
    end
    clear_inputs();
    check("mdu_start_count", 16'(st_cnt), 16'd1);
    check("mdu_stall_count", 16'(se_cnt), 16'(LAT));
    check("mdu_flushm_count", 16'(fm_cnt), 16'(LAT));
    check("mdu_busy_count", 16'(busy_cnt), 16'(LAT));
    @(negedge CLK);
    check("mdu_back_run", dut_vec(), 16'h0);
    advance();

    // Memory wait for two cycles while cnt is 2.
    se_cnt = 0; busy_cnt = 0;
    MduOpE = 1'b1;
    for (int i = 0; i <= LAT + 2; i++) begin
      MemAccessM = (i == 2 || i == 3);
      dmem_ready = !(i == 2 || i == 3);
      @(negedge CLK);
      se_cnt += int'(StallE); busy_cnt += int'(MduBusy);
      if (i == 2 || i == 3)
        check($sformatf("memwait_%0d", i), {12'd0, StallM, FlushW, FlushM, StallE}, 16'hd);
      advance();
    end
    clear_inputs();
    check("memwait_stall_total", 16'(se_cnt), 16'(LAT + 2));
    check("memwait_busy_total", 16'(busy_cnt), 16'(LAT + 2));
    @(negedge CLK);
    check("memwait_back_run", dut_vec(), 16'h0);
    advance();

    // Asynchronous reset while busy with cnt at 2.
    MduOpE = 1'b1;
    advance();
    advance();
    @(negedge CLK);
    check("arst_pre_busy", 16'(MduBusy), 16'd1);
    #2;
    MduOpE = 1'b0;
    rst = 1'b0;
    #1;
    check("arst_busy", 16'(MduBusy), 16'd0);
    check("arst_stalls", {12'd0, StallF, StallD, StallE, StallM}, 16'h0);
    advance();
    rst = 1'b1;
    @(negedge CLK);
    check("arst_run", dut_vec(), 16'h0);
    advance();
    @(negedge CLK);
    check("arst_no_start", dut_vec(), 16'h0);
    advance();

    // Random traffic against the occupancy model.
    done = 0;
    for (int c = 0; c < 600; c++) begin
      RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
      RsE = 5'($urandom_range(0, 3)); RtE = 5'($urandom_range(0, 3));
      WriteRegE = 5'($urandom_range(0, 3)); WriteRegM = 5'($urandom_range(0, 3));
      WriteRegW = 5'($urandom_range(0, 3));
      RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      MemtoRegE = ($urandom_range(0, 3) == 0); MemtoRegM = ($urandom_range(0, 3) == 0);
      BranchD = 1'($urandom); PCSrcD = ($urandom_range(0, 3) == 0);
      JumpD = ($urandom_range(0, 7) == 0); MduOpE = ($urandom_range(0, 3) == 0);
      MemAccessM = 1'($urandom); dmem_ready = 1'($urandom);
      @(negedge CLK);
      check($sformatf("rand_%0d", c), dut_vec(), model_vec());
      @(posedge CLK);
      model_clock();
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_sched_ctrl.md
# hazard_sched_ctrl

Pipeline hazard and stall scheduler for the 5-stage MIPS core. It drives the stall, flush and forwarding controls of the F/D, D/E, E/M and M/W pipeline registers. It resolves load-use and branch-compare hazards, sequences the fixed-latency multiply/divide unit (MDU) occupying the Execute stage, and freezes the pipe while data memory is not ready. It sits beside the datapath and contains the only stateful scheduling logic in the core.

## Interface
- MDU_LAT, 4, MDU latency in cycles (legal range 1..15); counter width is 4 bits.
- CLK  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- RsD, RtD  in  5 each  source register numbers in Decode.
- RsE, RtE  in  5 each  source register numbers in Execute.
- WriteRegE, WriteRegM, WriteRegW  in  5 each  destination register per stage.
- RegWriteE, RegWriteM, RegWriteW  in  1 each  register-write enables per stage.
- MemtoRegE, MemtoRegM  in  1 each  load-in-stage flags.
- BranchD, PCSrcD, JumpD  in  1 each  branch in D, branch taken, jump in D.
- MduOpE  in  1  MDU instruction in Execute.
- MemAccessM  in  1  load/store in Memory.
- dmem_ready  in  1  data memory ready; 0 means wait.
- StallF, StallD, StallE, StallM  out  1 each  hold enables.
- FlushD, FlushE, FlushM, FlushW  out  1 each  synchronous clears; FlushE drives CLR of the D/E register.
- ForwardAE, ForwardBE  out  2 each  00 = register file, 01 = W result, 10 = M ALU result.
- ForwardAD, ForwardBD  out  1 each  forward M ALU result to the branch comparator.
- MduStart  out  1  one-cycle MDU launch pulse.
- MduBusy  out  1  high in state MDU.

## Operation
- Forwarding is combinational.
  - ForwardAE = 10 if RsE≠0, RegWriteM and WriteRegM==RsE.
  - Otherwise ForwardAE = 01 if RsE≠0, RegWriteW and WriteRegW==RsE.
  - Otherwise ForwardAE = 00.
  - ForwardBE follows the same rules using RtE.
  - ForwardAD = RsD≠0 & RegWriteM & WriteRegM==RsD. ForwardBD follows the same rule using RtD.
- lwstall = MemtoRegE & (RtE==RsD | RtE==RtD).
- brstall = BranchD & ((RegWriteE & WriteRegE∈{RsD,RtD}) | (MemtoRegM & WriteRegM∈{RsD,RtD})).
- memwait = MemAccessM & ~dmem_ready.
- The FSM has two states, RUN and MDU, and a 4-bit counter cnt.
- RUN:
  - If MduOpE & ~memwait: MduStart=1, cnt ← MDU_LAT-1, next state MDU.
  - Otherwise stay in RUN.
- MDU:
  - MduOpE is ignored.
  - If memwait: cnt holds.
  - Else if cnt≠0: cnt decrements.
  - Else (cnt==0): next state RUN.
- mdustall = (RUN & MduOpE & ~memwait) | (MDU & cnt≠0).
- Output equations, in priority order:
  - StallM = FlushW = memwait.
  - StallE = memwait | mdustall.
  - FlushM = mdustall & ~memwait. This inserts a bubble into M while E holds.
  - StallF = StallD = StallE | lwstall | brstall.
  - FlushE = (lwstall | brstall) & ~StallE.
  - FlushD = (PCSrcD | JumpD) & ~StallD.
- Simultaneous events:
  - memwait dominates everything: no flush of D/E/M, and the MDU counter freezes.
  - An MDU op launching while memwait is high is deferred until memwait clears.
  - lwstall concurrent with mdustall produces a stall only, never a flush of E.

## Timing
- Reset (rst low, asynchronous): state=RUN, cnt=0.
- With all inputs 0, every output is 0.
- MDU occupancy, with MduOpE first high in RUN at cycle t:
  - Cycle t: MduStart=1. StallF/D/E=1. FlushM=1.
  - Cycles t+1 .. t+MDU_LAT: state MDU.
  - Stalls stay high through the cycle with cnt==1.
  - In the cycle with cnt==0, stalls drop and the op advances to M at that cycle's closing edge.
  - E occupancy is MDU_LAT+1 cycles; stall length is MDU_LAT cycles.
- MDU_LAT=1: MDU is entered with cnt=0, so there is exactly one stall cycle.
- Each cycle of memwait extends MDU occupancy by one cycle.
- Reset asserted mid-MDU returns to RUN immediately. No MduStart is issued until a new MduOpE is seen in RUN.
- lwstall costs one bubble.
- brstall lasts while the producer is in E (ALU op) or in E/M (load).

## Test plan
- Forwarding: RsE=RtE=3 with WriteRegM=3/RegWriteM=1 and WriteRegW=3/RegWriteW=1 → ForwardAE=ForwardBE=10. Repeat with RsE=0 → ForwardAE=00.
- Load-use: MemtoRegE=1, RtE=5, RsD=5 → StallF=StallD=FlushE=1 for exactly 1 cycle, StallE=0.
- MDU with MDU_LAT=4: MduOpE held high → MduStart one pulse, StallE high 4 cycles, FlushM high 4 cycles, MduBusy high 4 cycles, then RUN.
- Memory wait mid-MDU: dmem_ready=0 for 2 cycles during cnt=2 → StallM=FlushW=1, FlushM=0, cnt holds at 2, total StallE = 6 cycles.
- Taken branch during load-use: PCSrcD=1 with lwstall=1 → FlushD=0, StallD=1. On the next cycle (lwstall=0) → FlushD=1.
- Async reset in MDU with cnt=2: rst low mid-cycle → MduBusy=0 and all stalls 0 immediately, state RUN after release.
